spi_regmap_slave: RTL and testbench

// - SPI slave (mode 0, MSB first) in the system clock domain, fronting a byte-addressed register map.
// - An external SPI master writes and reads registers through framed transfers.
// - The register file is exposed to the core as a flat bus, with a write strobe for each byte written.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_regmap_slave.sv | 117 +++++++++++
 tb/tb_spi_regmap_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI header geometry and FSM state type for the register-map slave
package spi_pkg;
  localparam int SPI_HDR_W = 8;
  localparam int RW_BIT    = 7;
  localparam int ADDR_W    = 7;
  typedef enum logic [1:0] {IDLE, HDR, DATA} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_FF-deep synchronizer with one-clk rise/fall pulses; ports clk/rst, d_i async in, lvl_o synced level, rise_o/fall_o edge pulses
module spi_sync_edge #(
  parameter int   SYNC_FF = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_FF-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= {SYNC_FF{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= SYNC_FF'({sync_q, d_i});
      prev_q <= lvl_o;
    end
  assign lvl_o  = sync_q[SYNC_FF-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/spi_regmap_slave.sv
// spi_regmap_slave: SPI mode-0 slave fronting a byte register map; ports clk/rst, SPI pins, regs_o flat file, wr_stb_o/wr_addr_o commit strobe, busy_o frame active
module spi_regmap_slave
  import spi_pkg::*;
#(
  parameter int REG_BYTES = 32,
  parameter int SYNC_FF   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sclk,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic [REG_BYTES*8-1:0] regs_o,
  output logic                   wr_stb_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic                   busy_o
);
  localparam int AW = $clog2(REG_BYTES);
  localparam int CW = $clog2(SPI_HDR_W);
  spi_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SPI_HDR_W-2:0] sh_q, sh_d;
  logic [SPI_HDR_W-1:0] so_q, so_d, rx;
  logic [AW-1:0] addr_q, addr_d, hdr_addr;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [REG_BYTES-1:0][7:0] regs_q, regs_d;
  logic rw_q, rw_d, miso_q, miso_d, pend_q, pend_d, stb_q, byte_done;
  logic sclk_lvl, sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(spi_sclk), .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(spi_cs_n), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(spi_mosi), .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );
  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    so_d      = so_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    miso_d    = miso_q;
    regs_d    = regs_q;
    pend_d    = 1'b0;
    waddr_d   = waddr_q;
    rx        = {sh_q, mosi_lvl};
    hdr_addr  = rx[AW-1:0];
    byte_done = sclk_rise && state_q != IDLE && cnt_q == CW'(SPI_HDR_W - 1);
    if (state_q == IDLE && cs_fall) begin
      state_d = HDR;
      cnt_d   = '0;
      so_d    = '0;
    end
    if (sclk_rise && state_q != IDLE) begin
      sh_d  = rx[SPI_HDR_W-2:0];
      cnt_d = cnt_q + 1'b1;
    end
    if (sclk_fall && state_q != IDLE) begin
      miso_d = so_q[SPI_HDR_W-1];
      so_d   = {so_q[SPI_HDR_W-2:0], 1'b0};
    end
    if (byte_done && state_q == HDR) begin
      state_d = DATA;
      rw_d    = rx[RW_BIT];
      so_d    = rx[RW_BIT] ? regs_q[hdr_addr] : '0;
      addr_d  = rx[RW_BIT] ? hdr_addr + 1'b1 : hdr_addr;
    end
    // the read byte is latched at the boundary, before any write in this cycle
    if (byte_done && state_q == DATA) begin
      so_d    = rw_q ? regs_q[addr_q] : '0;
      pend_d  = !rw_q;
      waddr_d = rw_q ? waddr_q : ADDR_W'(addr_q);
      addr_d  = addr_q + 1'b1;
      if (!rw_q) regs_d[addr_q] = rx;
    end
    // a byte completing in the same clk as CS rising is committed above first
    if (cs_rise) state_d = IDLE;
    if (cs_lvl) miso_d = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      so_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      miso_q  <= 1'b0;
      regs_q  <= '0;
      pend_q  <= 1'b0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      miso_q  <= miso_d;
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      stb_q   <= pend_q;
      waddr_q <= waddr_d;
    end
  assign spi_miso  = miso_q;
  assign regs_o    = regs_q;
  assign wr_stb_o  = stb_q;
  assign wr_addr_o = waddr_q;
  assign busy_o    = ~cs_lvl;
endmodule

// File: tb/tb_spi_regmap_slave.sv
// tb_spi_regmap_slave: randomized SPI frames checked against a byte-level register-map model
module tb_spi_regmap_slave;
  localparam int RB = 32;
  logic clk = 0, rst = 1, spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0;
  logic spi_miso, wr_stb_o, busy_o;
  logic [RB*8-1:0] regs_o;
  logic [6:0] wr_addr_o;
  int tests = 0, fails = 0, stab = 0;
  logic cs_prev = 1'b1;
  logic [7:0] mdl[RB];
  logic [14:0] expq[$];
  logic [14:0] e;
  int stb_log[$];
  logic [7:0] rdq[$];
  logic [7:0] dq[$];
  spi_regmap_slave #(.REG_BYTES(RB), .SYNC_FF(2)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .regs_o(regs_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] rb(input int i);
    return regs_o[8*i +: 8];
  endfunction
  task automatic chk_regs(input string name);
    int bad = 0;
    for (int i = 0; i < RB; i++) if (rb(i) !== mdl[i]) bad++;
    chk(name, 32'(bad), 0);
  endtask
  // every-cycle checks: busy/miso once CS has settled, and each strobe against the expected commit order
  always @(negedge clk) begin
    if (rst) stab = 0;
    else begin
      stab = (spi_cs_n == cs_prev) ? stab + 1 : 0;
      if (stab >= 4) begin
        chk("busy", 32'(busy_o), 32'(!spi_cs_n));
        if (spi_cs_n) chk("miso_idle", 32'(spi_miso), 0);
      end
      if (wr_stb_o) begin
        chk("stb_pending", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("stb_addr", 32'(wr_addr_o), 32'(e[14:8]));
          chk("stb_data", 32'(rb(int'(e[14:8]))), 32'(e[7:0]));
        end
        stb_log.push_back(int'(wr_addr_o));
      end
    end
    cs_prev = spi_cs_n;
  end
  task automatic frame(input logic [7:0] hdr, input logic [7:0] dat[$], input int nbits, input int h,
                       input bit cs_last, input bit end_cs, input int gap);
    int a, k;
    bit rw;
    logic [7:0] cur, rd, gb;
    logic m;
    rw = hdr[7];
    a = 0;
    rd = '0;
    gb = '0;
    rdq = {};
    spi_cs_n = 0;
    repeat (h) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      k = i / 8;
      cur = (k == 0) ? hdr : dat[k-1];
      if (k > 0 && i % 8 == 0) rd = mdl[a];
      spi_mosi = cur[7 - i % 8];
      repeat (h) @(negedge clk);
      m = spi_miso;
      if (k > 0 && rw) begin
        chk($sformatf("miso_byte%0d_bit%0d", k - 1, 7 - i % 8), 32'(m), 32'(rd[7 - i % 8]));
        gb = {gb[6:0], m};
        if (i % 8 == 7) rdq.push_back(gb);
      end
      if (i == 7) a = int'(hdr[6:0]) % RB;
      else if (i % 8 == 7) begin
        if (!rw) begin
          expq.push_back({7'(a), cur});
          mdl[a] = cur;
        end
        a = (a + 1) % RB;
      end
      spi_sclk = 1;
      if (cs_last && i == nbits - 1) spi_cs_n = 1;
      repeat (h) @(negedge clk);
      spi_sclk = 0;
    end
    if (!cs_last) repeat (h) @(negedge clk);
    if (end_cs) spi_cs_n = 1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regs"}, 32'(regs_o != '0), 0);
    chk({tag, "_miso"}, 32'(spi_miso), 0);
    chk({tag, "_stb"}, 32'(wr_stb_o), 0);
    chk({tag, "_waddr"}, 32'(wr_addr_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] hdr;
    int nb, ex, nbits;
    for (int i = 0; i < RB; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    repeat (5) @(negedge clk);
    dq = {8'h17, 8'hf3, 8'had, 8'h08};
    stb_log = {};
    frame(8'h01, dq, 40, 5, 0, 1, 10);
    chk("t1_r1", 32'(rb(1)), 32'h17);
    chk("t1_r2", 32'(rb(2)), 32'hf3);
    chk("t1_r3", 32'(rb(3)), 32'had);
    chk("t1_r4", 32'(rb(4)), 32'h08);
    chk("t1_stb_count", 32'(stb_log.size()), 4);
    for (int i = 0; i < 4 && i < stb_log.size(); i++) chk($sformatf("t1_stb_addr%0d", i), 32'(stb_log[i]), 32'(i + 1));
    chk_regs("t1_regs");
    dq = {8'h00, 8'h00, 8'h00, 8'h00};
    frame(8'h81, dq, 40, 5, 0, 1, 10);
    chk("rd_count", 32'(rdq.size()), 4);
    if (rdq.size() == 4) begin
      chk("rd_b0", 32'(rdq[0]), 32'h17);
      chk("rd_b1", 32'(rdq[1]), 32'hf3);
      chk("rd_b2", 32'(rdq[2]), 32'had);
      chk("rd_b3", 32'(rdq[3]), 32'h08);
    end
    dq = {8'h17, 8'hf3, 8'had, 8'h08};
    frame(8'h02, dq, 40, 5, 0, 1, 1);
    dq = {8'hde, 8'had};
    stb_log = {};
    frame(8'h04, {8'h17, 8'hf3, 8'had, 8'h08, 8'hde, 8'had}, 56, 10, 0, 1, 10);
    chk("t2_r1", 32'(rb(1)), 32'h17);
    chk("t2_r2", 32'(rb(2)), 32'h17);
    chk("t2_r3", 32'(rb(3)), 32'hf3);
    chk("t3_r4", 32'(rb(4)), 32'h17);
    chk("t3_r7", 32'(rb(7)), 32'h08);
    chk("t3_r8", 32'(rb(8)), 32'hde);
    chk("t3_r9", 32'(rb(9)), 32'had);
    chk("t3_stb_count", 32'(stb_log.size()), 6);
    if (stb_log.size() == 6) chk("t3_stb_last", 32'(stb_log[5]), 9);
    chk_regs("t3_regs");
    stb_log = {};
    dq = {8'h5a, 8'hff};
    frame(8'h00, dq, 21, 5, 0, 1, 10);
    chk("part_r0", 32'(rb(0)), 32'h5a);
    chk("part_r1", 32'(rb(1)), 32'h17);
    chk("part_stb_count", 32'(stb_log.size()), 1);
    dq = {8'hc3, 8'h3c};
    frame(8'h1f, dq, 24, 4, 0, 1, 10);
    chk("wrap_r31", 32'(rb(31)), 32'hc3);
    chk("wrap_r0", 32'(rb(0)), 32'h3c);
    stb_log = {};
    dq = {8'ha5};
    frame(8'h0a, dq, 16, 6, 1, 1, 10);
    chk("cslast_r10", 32'(rb(10)), 32'ha5);
    chk("cslast_stb_count", 32'(stb_log.size()), 1);
    chk_regs("directed_regs");
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(0, 5);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      hdr = 8'($urandom);
      dq = {};
      repeat (nb + 1) dq.push_back(8'($urandom));
      nbits = 8 * (1 + nb) + ex;
      if ($urandom_range(0, 7) == 0) nbits = $urandom_range(1, 7);
      frame(hdr, dq, nbits, $urandom_range(4, 8), $urandom_range(0, 3) == 0, 1, $urandom_range(2, 12));
      repeat (12) @(negedge clk);
      chk_regs($sformatf("rand%0d_regs", f));
    end
    dq = {8'h11, 8'h22};
    frame(8'h03, dq, 20, 5, 0, 0, 0);
    chk("mid_r3", 32'(rb(3)), 32'h11);
    rst = 1;
    #1;
    chk_reset_outputs("midrst");
    spi_cs_n = 1;
    for (int i = 0; i < RB; i++) mdl[i] = '0;
    expq = {};
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    dq = {8'h99};
    frame(8'h05, dq, 16, 4, 0, 1, 10);
    chk("post_rst_r5", 32'(rb(5)), 32'h99);
    chk_regs("post_rst_regs");
    chk("expq_drained", 32'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
